adc_sampler: RTL

ADC_SAMPLER -- requirements
Module: adc_sampler

---
 rtl/adc_sampler_pkg.sv | 38 +++
 rtl/adc_sampler_if.sv | 24 ++
 rtl/adc_tick_gen.sv | 29 ++
 rtl/adc_sampler.sv | 138 +++++++++++++
 4 files changed

// File: rtl/adc_sampler_pkg.sv
// Shared types and constants for the LTC2308-style ADC sampler.
// Holds FSM states, sample width, meter-zero code and config bit layout.
package adc_sampler_pkg;

    localparam int SMP_W = 12;

    localparam logic [SMP_W-1:0] MIDSCALE = 12'h800;

    localparam int CFG_SD  = 11;
    localparam int CFG_OS  = 10;
    localparam int CFG_S1  = 9;
    localparam int CFG_S0  = 8;
    localparam int CFG_UNI = 7;
    localparam int CFG_SLP = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_SHIFT,
        ST_PUBLISH
    } state_t;

    // Single-ended, unipolar, awake; trailing bits stay zero.
    function automatic logic [SMP_W-1:0] cfg_word(
        input logic [2:0] ch
    );
        logic [SMP_W-1:0] w;
        w          = '0;
        w[CFG_SD]  = 1'b1;
        w[CFG_OS]  = ch[0];
        w[CFG_S1]  = ch[2];
        w[CFG_S0]  = ch[1];
        w[CFG_UNI] = 1'b1;
        w[CFG_SLP] = 1'b0;
        return w;
    endfunction

endpackage

// File: rtl/adc_sampler_if.sv
// Serial link between the sampler (master) and the ADC (slave).
// Signal names mirror the ADC pins.
interface adc_if;

    logic CONVST;
    logic SCK;
    logic SDI;
    logic SDO;

    modport master (
        output CONVST,
        output SCK,
        output SDI,
        input  SDO
    );

    modport slave (
        input  CONVST,
        input  SCK,
        input  SDI,
        output SDO
    );

endinterface

// File: rtl/adc_tick_gen.sv
// Free-running sample tick: counts 0..SAMPLE_PERIOD-1 and wraps.
// TICK is high during the terminal count cycle.
module adc_tick_gen #(
    parameter int SAMPLE_PERIOD = 1042
) (
    input  logic CLK,
    input  logic RESET_n,
    output logic TICK
);

    localparam int CW =
        (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_PERIOD - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign TICK = (r_cnt == LAST);

endmodule

// File: rtl/adc_sampler.sv
// Periodic ADC frame engine: CONVST, 12-bit SPI shift, then publish.
// Ticks that land while a frame is in flight are dropped with OVERRUN.
module adc_sampler
    import adc_sampler_pkg::*;
#(
    parameter int SAMPLE_PERIOD = 1042,
    parameter int CONV_CYCLES   = 80,
    parameter int CLK_DIV       = 2,
    parameter int TR_WIDTH      = 4
) (
    input  logic             CLK,
    input  logic             RESET_n,
    input  logic             ENABLE,
    input  logic [2:0]       CH_SEL,
    adc_if.master            ADC,
    output logic [SMP_W-1:0] VALUE,
    output logic             SAMPLE_TR,
    output logic             OVERRUN
);

    localparam logic [15:0] CONV_LAST   = 16'(CONV_CYCLES - 1);
    localparam logic [15:0] CONVST_LAST = 16'd1;
    localparam logic [15:0] DIV_HALF    = 16'(CLK_DIV);
    localparam logic [15:0] DIV_LAST    = 16'(2 * CLK_DIV - 1);
    localparam logic [15:0] PUB_LAST    = 16'(TR_WIDTH);
    localparam logic [3:0]  BIT_LAST    = 4'(SMP_W - 1);

    state_t           r_state;
    logic [15:0]      r_cnt;
    logic [15:0]      r_div;
    logic [3:0]       r_bit;
    logic [SMP_W-1:0] r_cfg;
    logic [SMP_W-1:0] r_shift;
    logic [SMP_W-1:0] r_value;
    logic             r_convst;
    logic             r_sck;
    logic             r_sdi;
    logic             r_tr;
    logic             r_ovr;

    logic             w_tick;
    logic             w_rise;
    logic [SMP_W-1:0] w_shift_nxt;

    adc_tick_gen #(
        .SAMPLE_PERIOD (SAMPLE_PERIOD)
    ) u_tick (
        .CLK     (CLK),
        .RESET_n (RESET_n),
        .TICK    (w_tick)
    );

    // SCK is high in this cycle for the first time: take SDO now.
    assign w_rise = (r_state == ST_SHIFT) && (r_div == DIV_HALF);
    assign w_shift_nxt = w_rise ?
        {r_shift[SMP_W-2:0], ADC.SDO} : r_shift;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_div    <= '0;
            r_bit    <= '0;
            r_cfg    <= '0;
            r_shift  <= '0;
            r_value  <= MIDSCALE;
            r_convst <= 1'b0;
            r_sck    <= 1'b0;
            r_sdi    <= 1'b0;
            r_tr     <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            r_ovr   <= w_tick && (r_state != ST_IDLE);
            r_shift <= w_shift_nxt;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_tick && ENABLE) begin
                        r_state  <= ST_CONV;
                        r_cnt    <= '0;
                        r_convst <= 1'b1;
                        r_cfg    <= cfg_word(CH_SEL);
                    end
                end
                ST_CONV: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (r_cnt >= CONVST_LAST) begin
                        r_convst <= 1'b0;
                    end
                    if (r_cnt == CONV_LAST) begin
                        r_state <= ST_SHIFT;
                        r_div   <= '0;
                        r_bit   <= '0;
                        r_sdi   <= r_cfg[SMP_W-1];
                        r_cfg   <= {r_cfg[SMP_W-2:0], 1'b0};
                    end
                end
                ST_SHIFT: begin
                    if (r_div == DIV_LAST) begin
                        r_div <= '0;
                        r_sck <= 1'b0;
                        if (r_bit == BIT_LAST) begin
                            r_state <= ST_PUBLISH;
                            r_cnt   <= '0;
                            r_sdi   <= 1'b0;
                            r_value <= w_shift_nxt;
                        end else begin
                            r_bit <= r_bit + 4'd1;
                            r_sdi <= r_cfg[SMP_W-1];
                            r_cfg <= {r_cfg[SMP_W-2:0], 1'b0};
                        end
                    end else begin
                        r_div <= r_div + 16'd1;
                        r_sck <= (r_div + 16'd1) >= DIV_HALF;
                    end
                end
                ST_PUBLISH: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (r_cnt == '0) begin
                        r_tr <= 1'b1;
                    end
                    if (r_cnt == PUB_LAST) begin
                        r_tr    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ADC.CONVST = r_convst;
    assign ADC.SCK    = r_sck;
    assign ADC.SDI    = r_sdi;
    assign VALUE      = r_value;
    assign SAMPLE_TR  = r_tr;
    assign OVERRUN    = r_ovr;

endmodule
